// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and defaults for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  localparam int NREQ_DEF    = 3;
  localparam int TIMEOUT_DEF = 65535;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search starting just after the last winner
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int          cand;
  logic [IW-1:0] cand_w;

  // Walk offsets from farthest to nearest so the nearest set request after last wins
  always_comb begin
    valid  = |req;
    idx    = '0;
    cand   = 0;
    cand_w = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand   = (int'(last) + k) % NREQ;
      cand_w = IW'(cand);
      if (req[cand_w]) idx = cand_w;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter; optional UART_TX_TIMEOUT_EN
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              trmt,
  output logic [7:0]        resp,
  input  logic              tx_done,
  output logic              busy,
  input  logic              clr_err,
  output logic              tmo_err
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   idx_q;
  logic [7:0]      resp_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            trmt_q;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [7:0]      pick_byte;
  logic            tmo_hit;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Select the winning requester's byte from the packed data bus
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_byte = req_data[8*i +: 8];
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          tmo_q;

  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign tmo_err = tmo_q;

  // Count WAIT cycles, restarting each time a byte is handed to the UART
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == TX) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Sticky timeout flag; a fresh timeout outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else if (state_q == WAIT && !tx_done && tmo_hit) begin
      tmo_q <= 1'b1;
    end else if (clr_err) begin
      tmo_q <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign tmo_hit    = 1'b0;
  assign tmo_err    = 1'b0;
  assign unused_cfg = clr_err | (TIMEOUT_CYC == 0);
`endif

  // Arbitration FSM with registered gnt/done/trmt pulses and the held byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      idx_q   <= '0;
      resp_q  <= 8'h00;
      gnt_q   <= '0;
      done_q  <= '0;
      trmt_q  <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      trmt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= TX;
            resp_q  <= pick_byte;
            idx_q   <= pick_idx;
            last_q  <= pick_idx;
            gnt_q   <= NREQ'(1) << pick_idx;
            trmt_q  <= 1'b1;
          end
        end
        TX: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            done_q  <= NREQ'(1) << idx_q;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign trmt = trmt_q;
  assign resp = resp_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;
  logic        busy;
  logic        clr_err;
  logic        tmo_err;

  int n_chk;
  int n_fail;

  uart_tx_arbiter #(.NREQ(3), .TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .trmt     (trmt),
    .resp     (resp),
    .tx_done  (tx_done),
    .busy     (busy),
    .clr_err  (clr_err),
    .tmo_err  (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [2:0] seen_done;
  logic [2:0] seen_gnt;
  logic [7:0] fair_bytes [3];
  int         fair_order [4];

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    clr_err  = 1'b0;
    rst_n    = 1'b0;

    // Reset state
    tick();
    check("rst_gnt",  32'(gnt),     32'h0);
    check("rst_done", 32'(done),    32'h0);
    check("rst_trmt", 32'(trmt),    32'h0);
    check("rst_busy", 32'(busy),    32'h0);
    check("rst_resp", 32'(resp),    32'h0);
    check("rst_tmo",  32'(tmo_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 1
    req      = 3'b010;
    req_data = 24'h00_A5_00;
    tick();
    check("single_trmt", 32'(trmt), 32'h1);
    check("single_gnt",  32'(gnt),  32'h2);
    check("single_resp", 32'(resp), 32'hA5);
    check("single_busy", 32'(busy), 32'h1);
    req = 3'b000;
    tick();
    check("single_wait_trmt", 32'(trmt), 32'h0);
    check("single_wait_gnt",  32'(gnt),  32'h0);
    seen_done = '0;
    for (int i = 0; i < 18; i++) begin
      tick();
      seen_done |= done;
    end
    check("single_no_early_done", 32'(seen_done), 32'h0);
    check("single_still_busy",    32'(busy),      32'h1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("single_done", 32'(done), 32'h2);
    check("single_idle", 32'(busy), 32'h0);
    check("single_resp_hold", 32'(resp), 32'hA5);
    tick();
    check("single_done_pulse", 32'(done), 32'h0);

    // Fairness with all three requesting continuously
    do_reset();
    fair_bytes[0] = 8'h10;
    fair_bytes[1] = 8'h21;
    fair_bytes[2] = 8'h32;
    fair_order[0] = 0;
    fair_order[1] = 1;
    fair_order[2] = 2;
    fair_order[3] = 0;
    req      = 3'b111;
    req_data = 24'h32_21_10;
    seen_gnt = '0;
    for (int r = 0; r < 4; r++) begin
      tick();
      check($sformatf("fair_gnt%0d", r),  32'(gnt),  32'(3'b001 << fair_order[r]));
      check($sformatf("fair_resp%0d", r), 32'(resp), 32'(fair_bytes[fair_order[r]]));
      check($sformatf("fair_trmt%0d", r), 32'(trmt), 32'h1);
      if (r < 3) begin
        check($sformatf("fair_once%0d", r), 32'(seen_gnt & gnt), 32'h0);
        seen_gnt |= gnt;
      end
      tick();
      check($sformatf("fair_wgnt%0d", r), 32'(gnt), 32'h0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check($sformatf("fair_done%0d", r), 32'(done), 32'(3'b001 << fair_order[r]));
      if (r == 3) req = 3'b000;
    end
    check("fair_all_granted", 32'(seen_gnt), 32'h7);
    tick();
    check("fair_quiet", 32'(busy), 32'h0);

    // Late request raised during WAIT of requester 0
    req      = 3'b001;
    req_data = 24'h77_00_55;
    tick();
    check("late_gnt0", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();
    req = 3'b100;
    seen_gnt = '0;
    tick();
    seen_gnt |= gnt;
    tick();
    seen_gnt |= gnt;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    seen_gnt |= gnt;
    check("late_done0",    32'(done),     32'h1);
    check("late_no_gnt2",  32'(seen_gnt), 32'h0);
    tick();
    check("late_gnt2",  32'(gnt),  32'h4);
    check("late_resp2", 32'(resp), 32'h77);
    req = 3'b000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("late_done2", 32'(done), 32'h4);
    tick();

    // Spurious tx_done in IDLE and TX
    tx_done  = 1'b1;
    tick();
    check("spur_idle_done", 32'(done), 32'h0);
    check("spur_idle_busy", 32'(busy), 32'h0);
    req      = 3'b010;
    req_data = 24'h00_3C_00;
    tick();
    check("spur_tx_trmt", 32'(trmt), 32'h1);
    check("spur_tx_done", 32'(done), 32'h0);
    req = 3'b000;
    tick();
    check("spur_wait_done", 32'(done), 32'h0);
    check("spur_wait_busy", 32'(busy), 32'h1);
    tick();
    tx_done = 1'b0;
    check("spur_real_done", 32'(done), 32'h2);
    check("spur_end_busy",  32'(busy), 32'h0);
    tick();

    // Reset in WAIT discards the byte
    do_reset();
    req      = 3'b001;
    req_data = 24'h00_00_E7;
    tick();
    req = 3'b000;
    tick();
    check("rw_in_wait", 32'(busy), 32'h1);
    rst_n   = 1'b0;
    tx_done = 1'b1;
    tick();
    check("rw_outs", 32'({gnt, done, trmt, busy, tmo_err}), 32'h0);
    check("rw_resp", 32'(resp), 32'h0);
    rst_n   = 1'b1;
    tx_done = 1'b0;
    tick();
    check("rw_no_done", 32'(done), 32'h0);
    req = 3'b001;
    tick();
    check("rw_regrant_gnt",  32'(gnt),  32'h1);
    check("rw_regrant_resp", 32'(resp), 32'hE7);
    req = 3'b000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("rw_regrant_done", 32'(done), 32'h1);
    tick();

`ifdef UART_TX_TIMEOUT_EN
    // Timeout after 16 WAIT cycles with no tx_done
    req      = 3'b001;
    req_data = 24'h00_00_99;
    tick();
    req = 3'b000;
    tick();
    seen_done = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_done |= done;
    end
    check("tmo_before_busy", 32'(busy),    32'h1);
    check("tmo_before_flag", 32'(tmo_err), 32'h0);
    tick();
    seen_done |= done;
    check("tmo_flag",    32'(tmo_err),   32'h1);
    check("tmo_busy",    32'(busy),      32'h0);
    check("tmo_no_done", 32'(seen_done), 32'h0);
    tick();
    check("tmo_sticky", 32'(tmo_err), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("tmo_cleared", 32'(tmo_err), 32'h0);
`else
    // Without the timeout, WAIT holds indefinitely and clr_err is inert
    req      = 3'b001;
    req_data = 24'h00_00_99;
    tick();
    req     = 3'b000;
    clr_err = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    clr_err = 1'b0;
    check("notmo_busy", 32'(busy),    32'h1);
    check("notmo_flag", 32'(tmo_err), 32'h0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("notmo_done", 32'(done), 32'h1);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters sharing the UART transmitter (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, number of cycles to wait for tx_done before aborting (used only with UART_TX_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester transmit request; held high until its gnt bit pulses.
REQ-006 SHALL have port req_data  input  8*NREQ  packed request bytes; requester i uses bits [8i+7:8i], stable while req[i] is high.
REQ-007 SHALL have port gnt  output  NREQ  one-cycle one-hot pulse: byte of requester i accepted.
REQ-008 SHALL have port done  output  NREQ  one-cycle one-hot pulse: byte of requester i fully transmitted.
REQ-009 SHALL have port trmt  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port resp  output  8  byte to the UART transmitter, registered, stable from the trmt pulse until the next grant.
REQ-011 SHALL have port tx_done  input  1  transmitter completion flag from the UART.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have ports clr_err  input  1  and tmo_err  output  1  (timeout clear and sticky timeout flag).

Function
REQ-014 SHALL implement states IDLE, TX, WAIT.
REQ-015 IDLE: when req is nonzero, SHALL pick one requester round-robin, register its byte into resp and its index, and go to TX; otherwise SHALL stay in IDLE.
REQ-016 Round-robin SHALL search from index (last+1) mod NREQ upward with wrap-around; last SHALL update to the granted index at grant time.
REQ-017 TX (one cycle): SHALL assert trmt=1 and gnt[idx]=1 together, then go to WAIT; latency from req rising in IDLE to trmt SHALL be exactly 1 cycle.
REQ-018 WAIT: on tx_done=1, SHALL pulse done[idx] for one cycle and return to IDLE; the next arbitration SHALL occur in the following IDLE cycle (minimum 3 cycles from grant to next grant).
REQ-019 SHALL ignore tx_done in IDLE and TX.
REQ-020 A requester raising req while another byte is in flight SHALL be considered only at the next IDLE cycle; requests SHALL never be lost while held.
REQ-021 gnt, done and trmt SHALL each be zero outside the cycles stated above; at most one bit of gnt and of done SHALL be high.

Reset
REQ-022 Reset SHALL force state=IDLE, last=NREQ-1 (requester 0 wins first), resp=8'h00, gnt=0, done=0, trmt=0, busy=0, tmo_err=0.
REQ-023 Reset asserted mid-transfer SHALL discard the in-flight byte with no done pulse.

Configuration
REQ-024 With macro UART_TX_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT_CYC without tx_done SHALL set tmo_err, return to IDLE with no done pulse, and leave last at the granted index.
REQ-025 tmo_err SHALL remain set until clr_err=1 or reset; clr_err and a new timeout in the same cycle SHALL leave tmo_err set.
REQ-026 Without UART_TX_TIMEOUT_EN, no counter SHALL exist, tmo_err SHALL be tied 0, clr_err SHALL be ignored, and WAIT SHALL wait indefinitely.

Structure
REQ-027 SHALL place the state enum (IDLE, TX, WAIT) and the default NREQ constant in package uart_arb_pkg.
REQ-028 SHALL place the round-robin search in combinational sub-module rr_picker (inputs req, last; outputs valid, idx).

Verification
REQ-029 Single request: req=3'b010, req_data[15:8]=8'hA5 -> next cycle trmt=1, gnt=3'b010, resp=8'hA5; tx_done 20 cycles later -> done=3'b010 for one cycle, busy low after.
REQ-030 Fairness: req=3'b111 held, bytes 8'h10/8'h21/8'h32 -> grant order 0,1,2,0 with matching resp values; each gnt exactly once per round.
REQ-031 Late request: req[2] raised during WAIT of req[0] -> no gnt[2] until cycle after done[0]; then gnt[2], resp=byte 2.
REQ-032 Spurious tx_done in IDLE and TX -> no done pulse, state sequence unchanged.
REQ-033 Reset asserted in WAIT -> next edge all outputs zero, no done pulse; after release req=3'b001 granted normally.
REQ-034 With UART_TX_TIMEOUT_EN, TIMEOUT_CYC=16, tx_done never asserted -> after 16 WAIT cycles tmo_err=1, busy=0, no done; clr_err pulse -> tmo_err=0.
